// File: rtl/data_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : data_lsu
//  Description : Multi-cycle load/store unit between EX and a word-addressed
//                data memory. Validates funct3 and alignment, formats store
//                lanes and byte enables, runs a req/ack memory handshake while
//                stalling the pipeline, and returns sign/zero-extended loads.
//
//  Ports
//    clk, rst          : core clock, synchronous active-high reset
//    ex_*              : memory instruction from EX (valid, load/store flags,
//                        funct3, byte address, store data, rd)
//    busy_o            : combinational stall request
//    mem_*             : request/ack interface to the data memory
//    wb_*              : load result to write-back (one-cycle valid pulse)
//    exc_o/exc_cause_o : abort pulse, cause 01 misaligned / 10 illegal
//
//  Revision    : 1.0 - initial release
// ============================================================================
module data_lsu #(
    parameter int DATA_WIDTH          = 32,
    parameter int DATA_MEM_ADDR_WIDTH = 10,
    parameter int REG_ADDR_WIDTH      = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ex_valid_i,
    input  logic                           ex_is_load_i,
    input  logic                           ex_is_store_i,
    input  logic [2:0]                     ex_funct3_i,
    input  logic [DATA_WIDTH-1:0]          ex_addr_i,
    input  logic [DATA_WIDTH-1:0]          ex_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0]      ex_rd_i,
    output logic                           busy_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]                     mem_be_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    input  logic                           mem_ack_i,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    output logic                           wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0]      wb_rd_o,
    output logic [DATA_WIDTH-1:0]          wb_data_o,
    output logic                           exc_o,
    output logic [1:0]                     exc_cause_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] c_CAUSE_ILLEGAL    = 2'b10;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;

    // Instruction context held across the access for load formatting.
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [2:0]                r_funct3;
    logic [1:0]                r_off;

    logic [REG_ADDR_WIDTH-1:0] w_rd_nxt;
    logic [2:0]                w_funct3_nxt;
    logic [1:0]                w_off_nxt;

    logic                           w_req_nxt;
    logic                           w_we_nxt;
    logic [DATA_MEM_ADDR_WIDTH-1:0] w_addr_nxt;
    logic [3:0]                     w_be_nxt;
    logic [DATA_WIDTH-1:0]          w_wdata_nxt;
    logic                           w_wb_valid_nxt;
    logic [REG_ADDR_WIDTH-1:0]      w_wb_rd_nxt;
    logic [DATA_WIDTH-1:0]          w_wb_data_nxt;
    logic                           w_exc_nxt;
    logic [1:0]                     w_exc_cause_nxt;

    // ------------------------------------------------------------------------
    // Decode of the instruction presented by EX
    // ------------------------------------------------------------------------
    logic       w_accept;
    logic       w_f3_ok;
    logic       w_illegal;
    logic       w_misaligned;
    logic       w_fault;
    logic [3:0] w_st_be;
    logic [DATA_WIDTH-1:0] w_st_wdata;

    // Address bits above the memory depth are intentionally dropped.
    logic w_unused_addr;
    assign w_unused_addr = ^ex_addr_i[DATA_WIDTH-1:DATA_MEM_ADDR_WIDTH+2];

    assign w_accept = ex_valid_i & (ex_is_load_i | ex_is_store_i);

    always_comb begin
        w_f3_ok = 1'b0;
        if (ex_is_load_i) begin
            w_f3_ok = (ex_funct3_i == c_F3_B)  || (ex_funct3_i == c_F3_H) ||
                      (ex_funct3_i == c_F3_W)  || (ex_funct3_i == c_F3_BU) ||
                      (ex_funct3_i == c_F3_HU);
        end else begin
            w_f3_ok = (ex_funct3_i == c_F3_B) || (ex_funct3_i == c_F3_H) ||
                      (ex_funct3_i == c_F3_W);
        end
    end

    assign w_illegal    = (ex_is_load_i & ex_is_store_i) | ~w_f3_ok;
    // funct3[1:0] encodes size for every legal access (01 half, 10 word).
    assign w_misaligned = ((ex_funct3_i[1:0] == 2'b01) &  ex_addr_i[0]) |
                          ((ex_funct3_i[1:0] == 2'b10) & (ex_addr_i[1:0] != 2'b00));
    assign w_fault      = w_illegal | w_misaligned;

    // Store lane formatting: replicate the datum so any enabled lane holds it.
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = ex_wdata_i;
        case (ex_funct3_i[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << ex_addr_i[1:0];
                w_st_wdata = {4{ex_wdata_i[7:0]}};
            end
            2'b01: begin
                w_st_be    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{ex_wdata_i[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = ex_wdata_i;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load result formatting from the acknowledged read word
    // ------------------------------------------------------------------------
    logic [7:0]            w_ld_byte;
    logic [15:0]           w_ld_half;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_ld_byte = mem_rdata_i[{r_off, 3'b000} +: 8];
    assign w_ld_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        w_ld_data = mem_rdata_i;
        case (r_funct3)
            c_F3_B:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            c_F3_BU: w_ld_data = {24'd0, w_ld_byte};
            c_F3_H:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            c_F3_HU: w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = mem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fault ? c_ST_DONE : c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (mem_ack_i) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (stall request and next values of output registers)
    // ------------------------------------------------------------------------
    always_comb begin
        busy_o          = 1'b0;
        w_req_nxt       = mem_req_o;
        w_we_nxt        = mem_we_o;
        w_addr_nxt      = mem_addr_o;
        w_be_nxt        = mem_be_o;
        w_wdata_nxt     = mem_wdata_o;
        w_wb_valid_nxt  = 1'b0;
        w_wb_rd_nxt     = wb_rd_o;
        w_wb_data_nxt   = wb_data_o;
        w_exc_nxt       = 1'b0;
        w_exc_cause_nxt = exc_cause_o;
        w_rd_nxt        = r_rd;
        w_funct3_nxt    = r_funct3;
        w_off_nxt       = r_off;

        case (r_state)
            c_ST_IDLE: begin
                busy_o = w_accept & ~rst;
                if (w_accept) begin
                    if (w_fault) begin
                        w_exc_nxt       = 1'b1;
                        // Illegal outranks misaligned when both apply.
                        w_exc_cause_nxt = w_illegal ? c_CAUSE_ILLEGAL
                                                    : c_CAUSE_MISALIGNED;
                    end else begin
                        w_req_nxt    = 1'b1;
                        w_we_nxt     = ex_is_store_i;
                        w_addr_nxt   = ex_addr_i[DATA_MEM_ADDR_WIDTH+1:2];
                        w_be_nxt     = w_st_be;
                        w_wdata_nxt  = w_st_wdata;
                        w_rd_nxt     = ex_rd_i;
                        w_funct3_nxt = ex_funct3_i;
                        w_off_nxt    = ex_addr_i[1:0];
                    end
                end
            end
            c_ST_REQ: begin
                busy_o = ~rst;
                if (mem_ack_i) begin
                    w_req_nxt = 1'b0;
                    if (!mem_we_o) begin
                        w_wb_data_nxt  = w_ld_data;
                        w_wb_rd_nxt    = r_rd;
                        // x0 is hardwired; a load to it never writes back.
                        w_wb_valid_nxt = (r_rd != '0);
                    end
                end
            end
            c_ST_DONE: begin
                busy_o    = 1'b0;
                w_req_nxt = 1'b0;
            end
            default: begin
                busy_o    = 1'b0;
                w_req_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output and context registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= '0;
            wb_valid_o  <= 1'b0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            exc_o       <= 1'b0;
            exc_cause_o <= 2'b00;
            r_rd        <= '0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
        end else begin
            mem_req_o   <= w_req_nxt;
            mem_we_o    <= w_we_nxt;
            mem_addr_o  <= w_addr_nxt;
            mem_be_o    <= w_be_nxt;
            mem_wdata_o <= w_wdata_nxt;
            wb_valid_o  <= w_wb_valid_nxt;
            wb_rd_o     <= w_wb_rd_nxt;
            wb_data_o   <= w_wb_data_nxt;
            exc_o       <= w_exc_nxt;
            exc_cause_o <= w_exc_cause_nxt;
            r_rd        <= w_rd_nxt;
            r_funct3    <= w_funct3_nxt;
            r_off       <= w_off_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_lsu
//  Description : Randomized self-checking bench for data_lsu against a
//                byte-addressed memory model and transaction-level rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_valid, r_ld, r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;
    logic [4:0]  r_rd;
    logic        r_ack;
    logic [31:0] r_rdata;

    logic        w_busy, w_req, w_we;
    logic [9:0]  w_maddr;
    logic [3:0]  w_be;
    logic [31:0] w_mwdata;
    logic        w_wb_valid;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_exc;
    logic [1:0]  w_cause;

    int n_vec = 0;
    int n_err = 0;

    // Byte-addressed model of the 4 KiB data memory.
    logic [7:0] mem_b [4096];

    always #5 clk = ~clk;

    data_lsu #(
        .DATA_WIDTH(32), .DATA_MEM_ADDR_WIDTH(10), .REG_ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(r_valid), .ex_is_load_i(r_ld), .ex_is_store_i(r_st),
        .ex_funct3_i(r_f3), .ex_addr_i(r_addr), .ex_wdata_i(r_wdata),
        .ex_rd_i(r_rd), .busy_o(w_busy),
        .mem_req_o(w_req), .mem_we_o(w_we), .mem_addr_o(w_maddr),
        .mem_be_o(w_be), .mem_wdata_o(w_mwdata),
        .mem_ack_i(r_ack), .mem_rdata_i(r_rdata),
        .wb_valid_o(w_wb_valid), .wb_rd_o(w_wb_rd), .wb_data_o(w_wb_data),
        .exc_o(w_exc), .exc_cause_o(w_cause)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input int widx);
        int b;
        b = (widx % 1024) * 4;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int base;
        logic [31:0] v;
        sz   = 1 << f3[1:0];
        base = int'(a % 4096);
        v    = 32'd0;
        for (int j = 0; j < sz; j++)
            v = v | (32'(mem_b[(base + j) % 4096]) << (8 * j));
        if (!f3[2] && sz < 4 && v[8*sz-1])
            v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    // Present one instruction at a falling edge with the DUT in IDLE; return
    // at a falling edge with the DUT back in IDLE.
    task automatic do_op(input logic v, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int waits);
        logic        acc, illegal, mis;
        int          sz;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [9:0]  exp_wa;

        r_valid = v; r_ld = ld; r_st = st; r_f3 = f3;
        r_addr = a; r_wdata = wd; r_rd = rd;
        r_ack = 1'($urandom_range(0, 1));   // stray ack outside REQ
        r_rdata = $urandom;
        #1;
        acc = v & (ld | st);
        chk_eq("busy_idle", 32'(w_busy), 32'(acc));
        if (!acc) begin
            @(posedge clk); @(negedge clk);
            r_ack = 1'b0;
            chk_eq("ignored_req", 32'(w_req), 32'd0);
            chk_eq("ignored_exc", 32'(w_exc), 32'd0);
            chk_eq("ignored_wbv", 32'(w_wb_valid), 32'd0);
            return;
        end

        sz = 1 << f3[1:0];
        if (ld && st) illegal = 1'b1;
        else if (ld)  illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else          illegal = (f3 > 3'd2);
        mis = (f3[1:0] != 2'b11) && ((a % sz) != 0);

        @(posedge clk); @(negedge clk);
        r_ack = 1'b0;
        if (illegal || mis) begin
            chk_eq("exc_pulse", 32'(w_exc), 32'd1);
            chk_eq("exc_cause", 32'(w_cause), illegal ? 32'd2 : 32'd1);
            chk_eq("exc_noreq", 32'(w_req), 32'd0);
            chk_eq("exc_busy",  32'(w_busy), 32'd0);
            @(posedge clk); @(negedge clk);
            chk_eq("exc_end",   32'(w_exc), 32'd0);
            chk_eq("exc_noreq2", 32'(w_req), 32'd0);
            return;
        end

        exp_wa = a[11:2];
        exp_be = 4'(((1 << sz) - 1) << (a % 4));
        exp_wd = 32'd0;
        for (int i = 0; i < 4; i++)
            exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];

        chk_eq("req_up",  32'(w_req), 32'd1);
        chk_eq("req_we",  32'(w_we), 32'(st));
        chk_eq("req_addr", 32'(w_maddr), 32'(exp_wa));
        chk_eq("req_busy", 32'(w_busy), 32'd1);
        if (st) begin
            chk_eq("req_be", 32'(w_be), 32'(exp_be));
            chk_eq("req_wdata", w_mwdata, exp_wd);
        end else begin
            chk_eq("req_be_ld", 32'(w_be), 32'(exp_be));
        end

        for (int k = 0; k < waits; k++) begin
            r_ack = 1'b0;
            r_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            chk_eq("wait_req",  32'(w_req), 32'd1);
            chk_eq("wait_addr", 32'(w_maddr), 32'(exp_wa));
            chk_eq("wait_busy", 32'(w_busy), 32'd1);
        end

        r_ack = 1'b1;
        r_rdata = st ? $urandom : model_word(int'(exp_wa));
        @(posedge clk); @(negedge clk);
        r_ack = 1'b0;
        r_rdata = $urandom;
        chk_eq("done_wbv", 32'(w_wb_valid), 32'(ld && rd != 5'd0));
        if (ld && rd != 5'd0) begin
            chk_eq("done_data", w_wb_data, model_load(f3, a));
            chk_eq("done_rd",   32'(w_wb_rd), 32'(rd));
        end
        chk_eq("done_req",  32'(w_req), 32'd0);
        chk_eq("done_exc",  32'(w_exc), 32'd0);
        chk_eq("done_busy", 32'(w_busy), 32'd0);
        if (st) begin
            for (int j = 0; j < sz; j++)
                mem_b[(int'(a % 4096) + j) % 4096] = wd[8*j +: 8];
        end
        @(posedge clk); @(negedge clk);
        chk_eq("idle_wbv", 32'(w_wb_valid), 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        ld, st;
        int          kind;

        for (int i = 0; i < 4096; i++) mem_b[i] = 8'($urandom);
        // LW test word at byte 8, LB/LBU/LHU test word at byte 0.
        {mem_b[11], mem_b[10], mem_b[9], mem_b[8]} = 32'hDEAD_BEEF;
        {mem_b[3],  mem_b[2],  mem_b[1], mem_b[0]} = 32'h80FF_0000;

        rst = 1'b1;
        r_valid = 1'b1; r_ld = 1'b1; r_st = 1'b0; r_f3 = 3'd2;
        r_addr = 32'd0; r_wdata = 32'd0; r_rd = 5'd1;
        r_ack = 1'b0; r_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_busy",  32'(w_busy), 32'd0);
        chk_eq("rst_req",   32'(w_req), 32'd0);
        chk_eq("rst_we",    32'(w_we), 32'd0);
        chk_eq("rst_addr",  32'(w_maddr), 32'd0);
        chk_eq("rst_be",    32'(w_be), 32'd0);
        chk_eq("rst_wdata", w_mwdata, 32'd0);
        chk_eq("rst_wbv",   32'(w_wb_valid), 32'd0);
        chk_eq("rst_wbd",   w_wb_data, 32'd0);
        chk_eq("rst_exc",   32'(w_exc), 32'd0);
        chk_eq("rst_cause", 32'(w_cause), 32'd0);
        r_valid = 1'b0;
        rst = 1'b0;

        // Directed cases.
        do_op(1, 1, 0, 3'd2, 32'h0000_0008, 32'd0, 5'd5, 3);          // LW
        do_op(1, 1, 0, 3'd0, 32'h0000_0003, 32'd0, 5'd6, 0);          // LB
        chk_eq("lb_value", w_wb_data, 32'hFFFF_FF80);
        do_op(1, 1, 0, 3'd4, 32'h0000_0003, 32'd0, 5'd7, 0);          // LBU
        chk_eq("lbu_value", w_wb_data, 32'h0000_0080);
        do_op(1, 1, 0, 3'd5, 32'h0000_0002, 32'd0, 5'd8, 0);          // LHU
        chk_eq("lhu_value", w_wb_data, 32'h0000_80FF);
        do_op(1, 0, 1, 3'd0, 32'h0000_0101, 32'h1234_56AB, 5'd0, 1);  // SB
        do_op(1, 0, 1, 3'd1, 32'h0000_0006, 32'h0000_CAFE, 5'd0, 0);  // SH
        do_op(1, 1, 0, 3'd2, 32'h0000_0002, 32'd0, 5'd3, 0);          // LW mis
        do_op(1, 1, 0, 3'd1, 32'h0000_0001, 32'd0, 5'd3, 0);          // LH mis
        do_op(1, 0, 1, 3'd3, 32'h0000_0000, 32'd0, 5'd0, 0);          // bad st
        do_op(1, 1, 1, 3'd2, 32'h0000_0001, 32'd0, 5'd3, 0);          // both
        do_op(1, 0, 0, 3'd2, 32'h0000_0000, 32'd0, 5'd3, 0);          // neither
        do_op(1, 1, 0, 3'd2, 32'hFFFF_F00C, 32'd0, 5'd0, 0);          // rd=0, wrap
        do_op(1, 1, 0, 3'd2, 32'h0000_0010, 32'd0, 5'd9, 0);          // back-to-back
        do_op(1, 1, 0, 3'd2, 32'h0000_0014, 32'd0, 5'd10, 0);

        // Reset while in REQ, with the ack arriving in the following cycle.
        r_valid = 1'b1; r_ld = 1'b1; r_st = 1'b0; r_f3 = 3'd2;
        r_addr = 32'h0000_0020; r_rd = 5'd11; r_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_eq("rreq_up", 32'(w_req), 32'd1);
        rst = 1'b1;
        #1;
        chk_eq("rreq_busy_rst", 32'(w_busy), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        r_valid = 1'b0;
        r_ack = 1'b1;
        r_rdata = 32'h5555_AAAA;
        chk_eq("rreq_req",  32'(w_req), 32'd0);
        chk_eq("rreq_addr", 32'(w_maddr), 32'd0);
        chk_eq("rreq_wbd",  w_wb_data, 32'd0);
        chk_eq("rreq_busy", 32'(w_busy), 32'd0);
        @(posedge clk); @(negedge clk);
        r_ack = 1'b0;
        chk_eq("rreq_wbv", 32'(w_wb_valid), 32'd0);
        chk_eq("rreq_req2", 32'(w_req), 32'd0);
        chk_eq("rreq_wbd2", w_wb_data, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            ld = (kind == 1) || (kind >= 2 && kind <= 5);
            st = (kind == 1) || (kind >= 6);
            if ($urandom_range(0, 6) == 0)
                f3 = 3'($urandom);
            else if (ld && !st)
                f3 = 3'($urandom_range(0, 4)) + ((3'($urandom_range(0, 4)) >= 3'd3) ? 3'd1 : 3'd0);
            else
                f3 = 3'($urandom_range(0, 2));
            if (ld && !st && f3 == 3'd3) f3 = 3'd4;
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            do_op(1'($urandom_range(0, 7) != 0), ld, st, f3, a, $urandom,
                  5'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
